fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32 single-cycle core. It holds the PC, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers responses in a small queue. It presents one instruction per cycle, with its PC and PC+4, to the combinational decoder. Branch and jalr redirects from the decode/execute path flush the queue and discard stale in-flight responses.

---
 rtl/rv_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv_pkg
// Description : RV32 core-wide constants and types shared by fetch and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Shift-register {pc, inst} queue; slot 0 is the registered head.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [2*XLEN-1:0]       i_data,
    output logic [2*XLEN-1:0]       o_head,
    output logic                    o_valid,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [2*XLEN-1:0]  r_mem [DEPTH];
    logic [2*XLEN-1:0]  w_above [DEPTH];
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_wr_idx;

    // A simultaneous pop shifts everything down, so the new entry lands one slot lower.
    assign w_wr_idx = i_pop ? r_count - c_cnt_w'(1) : r_count;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_above
        if (gi < DEPTH - 1) begin : g_mid
            assign w_above[gi] = r_mem[gi+1];
        end else begin : g_top
            assign w_above[gi] = r_mem[gi];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_push && w_wr_idx == c_cnt_w'(i)) begin
                r_mem[i] <= i_data;
            end else if (i_pop) begin
                r_mem[i] <= w_above[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(i_push) - c_cnt_w'(i_pop);
        end
    end

    assign o_head  = r_mem[0];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && !i_flush && r_count == c_cnt_w'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && r_count == '0));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32 instruction fetch: PC, credit-limited imem requests,
//               response queue and redirect flush with stale-response drop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_drop_cnt;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w:0]   w_credit_used;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_inst_valid;
    logic               w_unused_lsbs;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    // Every in-flight request already owns a queue slot, so a push can never overflow.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_req_valid   = !rst && !redirect && (w_credit_used < (c_cnt_w+1)'(DEPTH));
    assign w_req_fire    = w_req_valid && imem_req_ready;
    assign w_push        = imem_rsp_valid && (r_drop_cnt == '0) && !redirect;
    assign w_pop         = w_inst_valid && inst_ready_i;
    assign w_push_entry  = '{pc: r_rsp_pc, inst: imem_rsp_data};
    assign w_unused_lsbs = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= word_align(RESET_PC);
            r_rsp_pc      <= word_align(RESET_PC);
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(imem_rsp_valid);
            if (redirect) begin
                r_fetch_pc <= word_align(redirect_pc);
                r_rsp_pc   <= word_align(redirect_pc);
                // A response landing this cycle is already discarded, so it is not counted.
                r_drop_cnt <= r_outstanding - c_cnt_w'(imem_rsp_valid);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (imem_rsp_valid && r_drop_cnt != '0) begin
                    r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_valid (w_inst_valid),
        .o_count (w_count)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid_o   = w_inst_valid;
    assign inst_o         = w_inst_valid ? w_head.inst : NOP_INST;
    assign pc_o           = w_inst_valid ? w_head.pc : '0;
    assign pc4_o          = w_inst_valid ? w_head.pc + 32'd4 : 32'd4;

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (r_outstanding != '0));
    a_outstanding_cap: assert property (@(posedge clk) disable iff (rst)
        w_req_fire |-> (r_outstanding != c_cnt_w'(DEPTH)));
    a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
        r_drop_cnt <= r_outstanding);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomised fetch_unit bench with memory model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam int          c_depth    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (c_reset_pc),
        .DEPTH    (c_depth)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .pc4_o          (pc4_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    exp_t        exp_q[$];
    req_t        pend[$];
    bit          valid_log[int];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_req_addr;
    int          last_due = 0;

    // stimulus knobs
    bit          rst_knob = 1'b1;
    int          rdy_pct = 100;
    int          req_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          redir_pct = 0;
    bit          toggle_req = 1'b0;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt = '0;
    int          need_out = -1;
    bit          need_rsp = 1'b0;
    int          redir_cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        model_pc     = c_reset_pc;
        exp_req_addr = c_reset_pc;
        last_due     = 0;
    endtask

    // Architectural instruction stream the core must deliver, in order.
    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc), pc4: model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic step();
        int          out_now;
        int          lat;
        int          due;
        bit          do_redir;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        rst            = rst_knob;
        redirect       = 1'b0;
        redirect_pc    = $urandom;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        inst_ready_i   = !rst_knob && (int'($urandom_range(99, 0)) < rdy_pct);
        imem_req_ready = toggle_req ? cyc[0] : (int'($urandom_range(99, 0)) < req_pct);
        if (rst_knob) begin
            model_reset();
            topup();
        end else begin
            out_now = pend.size();
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end
            do_redir = 1'b0;
            if (inst_valid_o && inst_ready_i) begin
                if (force_redir) begin
                    do_redir = (need_out < 0 || need_out == out_now) && (!need_rsp || imem_rsp_valid);
                end else begin
                    do_redir = int'($urandom_range(99, 0)) < redir_pct;
                end
            end
            if (do_redir) begin
                tgt         = force_redir ? force_tgt : $urandom;
                redirect    = 1'b1;
                redirect_pc = tgt;
                if (force_redir) begin
                    force_redir = 1'b0;
                    redir_cyc   = cyc;
                end
            end
        end
        #1;
        valid_log[cyc] = inst_valid_o;
        if (!rst_knob) begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_req_addr);
                lat = int'($urandom_range(lat_max, lat_min));
                due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                pend.push_back('{addr: imem_req_addr, due: due});
                last_due     = due;
                exp_req_addr = exp_req_addr + 32'd4;
            end
            if (redirect) begin
                check("req_in_redirect", 32'(imem_req_valid), 32'd0);
                exp_req_addr = {redirect_pc[31:2], 2'b00};
                while (exp_q.size() > 1) void'(exp_q.pop_back());
                model_pc = exp_req_addr;
            end
            n_cmp++;
            if (pend.size() > c_depth) begin
                n_bad++;
                $display("FAIL outstanding_cap: got %0d, expected <= %0d", pend.size(), c_depth);
            end
            topup();
        end
    endtask

    task automatic wait_redirect(input string name);
        int n = 0;
        while (force_redir && n < 200) begin
            step();
            n++;
        end
        n_cmp++;
        if (force_redir) begin
            n_bad++;
            $display("FAIL %s: got no redirect, expected one within 200 cycles", name);
            force_redir = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, "_inst"}, inst_o, NOP_INST);
        check({tag, "_pc"}, pc_o, 32'd0);
        check({tag, "_pc4"}, pc4_o, 32'd4);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    endtask

    // Scoreboard monitor: samples just before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (inst_valid_o) begin
                    if (inst_ready_i) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL sb_empty: got pc %h, expected nothing", pc_o);
                        end else begin
                            e = exp_q.pop_front();
                            check("pc_o", pc_o, e.pc);
                            check("inst_o", inst_o, e.inst);
                            check("pc4_o", pc4_o, e.pc4);
                        end
                    end
                end else begin
                    check("idle_inst", inst_o, NOP_INST);
                    check("idle_pc", pc_o, 32'd0);
                    check("idle_pc4", pc4_o, 32'd4);
                end
            end
        end
    end

    initial begin
        int rel;
        int sum;
        model_reset();
        topup();

        rst_knob = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");

        // Reset release with 1-cycle memory and a ready consumer.
        rst_knob = 1'b0;
        step();
        rel = cyc;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, c_reset_pc);
        repeat (20) step();
        check("not_valid_at_1", 32'(valid_log[rel+1]), 32'd0);
        check("valid_at_2", 32'(valid_log[rel+2]), 32'd1);
        sum = 0;
        for (int i = rel + 2; i <= rel + 20; i++) sum += int'(valid_log[i]);
        check("throughput", 32'(sum), 32'd19);

        // Consumer stall: credits exhaust and requests stop.
        rdy_pct = 0;
        repeat (10) step();
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        rdy_pct = 100;
        repeat (15) step();

        // Memory ready toggling.
        toggle_req = 1'b1;
        repeat (30) step();
        toggle_req = 1'b0;

        // Redirect with 3 requests outstanding, 3-cycle memory.
        lat_min = 3;
        lat_max = 3;
        repeat (10) step();
        force_tgt   = 32'h0000_0103;
        need_out    = 3;
        need_rsp    = 1'b0;
        force_redir = 1'b1;
        wait_redirect("redir_lat3");
        repeat (12) step();
        check("lat3_redir_r1", 32'(valid_log[redir_cyc+1]), 32'd0);
        check("lat3_redir_r5", 32'(valid_log[redir_cyc+5]), 32'd1);

        // Redirect coinciding with a response and a pop, 1-cycle memory.
        lat_min = 1;
        lat_max = 1;
        repeat (6) step();
        force_tgt   = 32'h0000_2000;
        need_out    = -1;
        need_rsp    = 1'b1;
        force_redir = 1'b1;
        wait_redirect("redir_lat1");
        repeat (8) step();
        check("lat1_redir_r1", 32'(valid_log[redir_cyc+1]), 32'd0);
        check("lat1_redir_r2", 32'(valid_log[redir_cyc+2]), 32'd0);
        check("lat1_redir_r3", 32'(valid_log[redir_cyc+3]), 32'd1);

        // Address wrap at the top of the address space.
        force_tgt   = 32'hFFFF_FFFC;
        need_rsp    = 1'b0;
        force_redir = 1'b1;
        wait_redirect("redir_wrap");
        repeat (12) step();

        // Randomised traffic.
        lat_min   = 1;
        lat_max   = 4;
        rdy_pct   = 75;
        req_pct   = 70;
        redir_pct = 4;
        repeat (3000) step();

        // Reset mid-operation.
        rst_knob = 1'b1;
        repeat (2) step();
        check_reset_outputs("midreset");
        rst_knob = 1'b0;
        repeat (500) step();

        rdy_pct   = 100;
        redir_pct = 0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
